// File: rtl/byte_serializer.sv
// Byte-to-serial converter: buffers qualified bytes in a small FIFO and shifts
// each one out MSB-first with a valid strobe and a last-bit marker.
module byte_serializer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        data_in,
    input  logic              data_en,
    output logic              ser_o,
    output logic              ser_valid,
    output logic              ser_last,
    output logic [ADDR_W:0]   fifo_cnt,
    output logic              overflow,
    output logic              busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [7:0]        rd_data;

    state_t            state_reg, state_next;
    logic [2:0]        bit_cnt_reg, bit_cnt_next;
    logic [7:0]        byte_reg, byte_next;
    logic              ser_o_reg, ser_o_next;
    logic              ser_valid_reg, ser_valid_next;
    logic              ser_last_reg, ser_last_next;
    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W:0]   cnt_reg, cnt_next;
    logic              overflow_reg, overflow_next;

    logic              pop;
    logic              push;

    // A pop frees a slot on the same edge, so a full FIFO still accepts then.
    assign pop     = (cnt_reg != '0) && ((state_reg == IDLE) || (bit_cnt_reg == 3'd7));
    assign push    = data_en && ((cnt_reg != FULL_CNT) || pop);
    assign rd_data = mem[rd_ptr_reg];

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        byte_next      = byte_reg;
        ser_o_next     = ser_o_reg;
        ser_valid_next = ser_valid_reg;
        ser_last_next  = ser_last_reg;

        case (state_reg)
            IDLE: begin
                if (pop) begin
                    state_next     = SHIFT;
                    byte_next      = rd_data;
                    bit_cnt_next   = 3'd0;
                    ser_o_next     = rd_data[7];
                    ser_valid_next = 1'b1;
                    ser_last_next  = 1'b0;
                end
            end
            SHIFT: begin
                if (bit_cnt_reg != 3'd7) begin
                    bit_cnt_next  = bit_cnt_reg + 3'd1;
                    ser_o_next    = byte_reg[~bit_cnt_next];
                    ser_last_next = (bit_cnt_reg == 3'd6);
                end else if (pop) begin
                    // Next byte follows immediately with no gap cycle.
                    byte_next      = rd_data;
                    bit_cnt_next   = 3'd0;
                    ser_o_next     = rd_data[7];
                    ser_valid_next = 1'b1;
                    ser_last_next  = 1'b0;
                end else begin
                    state_next     = IDLE;
                    ser_o_next     = 1'b0;
                    ser_valid_next = 1'b0;
                    ser_last_next  = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        cnt_next      = cnt_reg;
        overflow_next = overflow_reg | (data_en & ~push);

        if (push) begin
            wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
        end

        case ({push, pop})
            2'b10:   cnt_next = cnt_reg + (ADDR_W+1)'(1);
            2'b01:   cnt_next = cnt_reg - (ADDR_W+1)'(1);
            default: cnt_next = cnt_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= 3'd0;
            byte_reg      <= 8'd0;
            ser_o_reg     <= 1'b0;
            ser_valid_reg <= 1'b0;
            ser_last_reg  <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            cnt_reg       <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            byte_reg      <= byte_next;
            ser_o_reg     <= ser_o_next;
            ser_valid_reg <= ser_valid_next;
            ser_last_reg  <= ser_last_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            cnt_reg       <= cnt_next;
            overflow_reg  <= overflow_next;
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    assign ser_o     = ser_o_reg;
    assign ser_valid = ser_valid_reg;
    assign ser_last  = ser_last_reg;
    assign fifo_cnt  = cnt_reg;
    assign overflow  = overflow_reg;
    assign busy      = (state_reg == SHIFT) || (cnt_reg != '0);

endmodule

// File: tb/tb_byte_serializer.sv
// Self-checking bench for byte_serializer: a schedule-based reference model
// (each accepted byte gets a start edge) checked every cycle, plus directed cases.
module tb_byte_serializer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk;
    logic              reset_n;
    logic [7:0]        data_in;
    logic              data_en;
    logic              ser_o;
    logic              ser_valid;
    logic              ser_last;
    logic [ADDR_W:0]   fifo_cnt;
    logic              overflow;
    logic              busy;

    int checks = 0;
    int errors = 0;

    byte_serializer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .data_in  (data_in),
        .data_en  (data_en),
        .ser_o    (ser_o),
        .ser_valid(ser_valid),
        .ser_last (ser_last),
        .fifo_cnt (fifo_cnt),
        .overflow (overflow),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: byte k is shown during edges start..start+7, where
    // start = max(accept_edge+1, previous_start+8).
    int         now = 0;
    int         acc_q[$];
    int         start_q[$];
    logic [7:0] byte_q[$];
    int         last_start = -100;
    bit         m_ovf = 0;
    bit         model_live = 0;
    logic       exp_o, exp_valid, exp_last, exp_busy;
    int         exp_cnt;

    always @(posedge clk) begin
        int cnt;
        bit pop_now;
        int s;
        now++;
        model_live = 1;
        if (!reset_n) begin
            acc_q.delete();
            start_q.delete();
            byte_q.delete();
            last_start = -100;
            m_ovf = 0;
        end else begin
            while (start_q.size() > 0 && start_q[0] + 8 <= now) begin
                void'(acc_q.pop_front());
                void'(start_q.pop_front());
                void'(byte_q.pop_front());
            end
            cnt = 0;
            pop_now = 0;
            foreach (acc_q[i]) begin
                if (acc_q[i] < now) cnt++;
                if (start_q[i] < now) cnt--;
                if (start_q[i] == now) pop_now = 1;
            end
            if (data_en) begin
                if (cnt < DEPTH || pop_now) begin
                    s = (now + 1 > last_start + 8) ? now + 1 : last_start + 8;
                    acc_q.push_back(now);
                    start_q.push_back(s);
                    byte_q.push_back(data_in);
                    last_start = s;
                end else begin
                    m_ovf = 1;
                end
            end
        end
        exp_o = 0; exp_valid = 0; exp_last = 0; exp_cnt = 0;
        foreach (acc_q[i]) begin
            if (acc_q[i] <= now) exp_cnt++;
            if (start_q[i] <= now) exp_cnt--;
            if (start_q[i] <= now && now < start_q[i] + 8) begin
                exp_valid = 1;
                exp_o     = byte_q[i][7 - (now - start_q[i])];
                exp_last  = (now - start_q[i] == 7);
            end
        end
        exp_busy = exp_valid || (exp_cnt != 0);
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("ser_o",     ser_o,     exp_o);
            chk("ser_valid", ser_valid, exp_valid);
            chk("ser_last",  ser_last,  exp_last);
            chk("fifo_cnt",  fifo_cnt,  exp_cnt);
            chk("overflow",  overflow,  m_ovf);
            chk("busy",      busy,      exp_busy);
        end
    end

    // Observation of the serial stream for the directed cases.
    logic obs_bits[$];
    logic obs_lastf[$];
    int   cyc = 0;
    int   obs_first = -1;
    int   obs_end = -1;

    always @(negedge clk) begin
        cyc++;
        if (ser_valid === 1'b1) begin
            obs_bits.push_back(ser_o);
            obs_lastf.push_back(ser_last);
            if (obs_first < 0) obs_first = cyc;
            obs_end = cyc;
        end
    end

    task automatic obs_clear();
        obs_bits.delete();
        obs_lastf.delete();
        obs_first = -1;
        obs_end = -1;
    endtask

    function automatic logic [63:0] obs_value();
        logic [63:0] v = '0;
        foreach (obs_bits[i]) v = {v[62:0], obs_bits[i]};
        return v;
    endfunction

    function automatic logic [63:0] obs_last_mask();
        logic [63:0] v = '0;
        foreach (obs_lastf[i]) v = {v[62:0], obs_lastf[i]};
        return v;
    endfunction

    task automatic step(input logic en, input logic [7:0] d, input logic rn);
        @(negedge clk);
        data_en = en;
        data_in = d;
        reset_n = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((ser_valid !== 1'b0 || busy !== 1'b0) && n < 200) begin
            step(1'b0, 8'h00, 1'b1);
            n++;
        end
        chk("drain_bound", (n < 200), 1);
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic check_stream(input string name, input int nbits,
                                input logic [63:0] bits, input logic [63:0] lastm);
        chk({name, "_count"}, obs_bits.size(), nbits);
        chk({name, "_bits"},  obs_value(), bits);
        chk({name, "_last"},  obs_last_mask(), lastm);
        chk({name, "_span"},  obs_end - obs_first + 1, nbits);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int rate;
        reset_n = 1'b0;
        data_en = 1'b1;
        data_in = 8'hFF;

        // 1: reset with data_en asserted
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 8'hFF, 1'b0);
            chk("rst_valid", ser_valid, 0);
            chk("rst_o",     ser_o,     0);
            chk("rst_last",  ser_last,  0);
            chk("rst_cnt",   fifo_cnt,  0);
            chk("rst_ovf",   overflow,  0);
            chk("rst_busy",  busy,      0);
        end
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        $display("case reset done");

        // 2: single byte 0xA5
        obs_clear();
        step(1'b1, 8'hA5, 1'b1);
        chk("single_cnt_e0", fifo_cnt, 1);
        step(1'b0, 8'h00, 1'b1);
        chk("single_cnt_e1", fifo_cnt, 0);
        chk("single_first_bit", ser_o, 1);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);
        chk("single_last_e8", ser_last, 1);
        step(1'b0, 8'h00, 1'b1);
        chk("single_valid_e9", ser_valid, 0);
        chk("single_busy_e9", busy, 0);
        check_stream("single", 8, 64'hA5, 64'h01);
        $display("case single byte 0xA5 done");

        // 3: back-to-back bytes
        obs_clear();
        step(1'b1, 8'h3C, 1'b1);
        step(1'b1, 8'hFF, 1'b1);
        drain();
        check_stream("b2b", 16, 64'h3CFF, 64'h0101);
        $display("case back-to-back 0x3C 0xFF done");

        // 4: overflow
        obs_clear();
        begin
            logic [ADDR_W:0] exp_c [6];
            exp_c = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
            for (int i = 0; i < 6; i++) begin
                step(1'b1, 8'(i + 1), 1'b1);
                chk("ovf_cnt", fifo_cnt, exp_c[i]);
                chk("ovf_flag", overflow, (i == 5));
            end
        end
        drain();
        chk("ovf_sticky", overflow, 1);
        check_stream("ovf", 40, 64'h0102030405, 64'h0101010101);
        step(1'b0, 8'h00, 1'b0);
        chk("ovf_cleared", overflow, 0);
        step(1'b0, 8'h00, 1'b1);
        $display("case overflow done");

        // 5: push on the pop edge while full
        obs_clear();
        step(1'b1, 8'hA1, 1'b1);
        step(1'b1, 8'hB2, 1'b1);
        step(1'b1, 8'hC3, 1'b1);
        step(1'b1, 8'hD4, 1'b1);
        step(1'b1, 8'hE5, 1'b1);
        chk("full_cnt_e4", fifo_cnt, 4);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
        chk("full_last_e8", ser_last, 1);
        step(1'b1, 8'h77, 1'b1);
        chk("full_cnt_e9", fifo_cnt, 4);
        chk("full_ovf_e9", overflow, 0);
        drain();
        check_stream("full", 48, 64'hA1B2C3D4E577, 64'h010101010101);
        chk("full_ovf_end", overflow, 0);
        $display("case push on pop edge done");

        // 6: reset mid-byte
        step(1'b1, 8'hF0, 1'b1);
        step(1'b1, 8'h12, 1'b1);
        step(1'b1, 8'h34, 1'b1);
        chk("mid_cnt", fifo_cnt, 2);
        step(1'b0, 8'h00, 1'b0);
        chk("mid_valid", ser_valid, 0);
        chk("mid_cnt_rst", fifo_cnt, 0);
        obs_clear();
        step(1'b1, 8'h81, 1'b1);
        drain();
        check_stream("mid", 8, 64'h81, 64'h01);
        $display("case reset mid-byte done");

        // Randomized traffic at varying offered load, with rare resets.
        rate = 10;
        for (int i = 0; i < 3000; i++) begin
            if (i % 256 == 0) begin
                case ($urandom_range(0, 3))
                    0: rate = 5;
                    1: rate = 12;
                    2: rate = 30;
                    default: rate = 80;
                endcase
            end
            step(($urandom_range(0, 99) < rate), 8'($urandom),
                 ($urandom_range(0, 499) != 0));
        end
        drain();
        $display("case random traffic done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
